// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART receiver/transmitter state encoding and bit timing.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_st_w = 3;

    localparam logic [c_st_w-1:0] c_st_idle  = 3'd0;
    localparam logic [c_st_w-1:0] c_st_start = 3'd1;
    localparam logic [c_st_w-1:0] c_st_data  = 3'd2;
    localparam logic [c_st_w-1:0] c_st_stop  = 3'd3;
    localparam logic [c_st_w-1:0] c_st_break = 3'd4;

    // Integer truncation: a slightly fast bit period keeps mid-bit sampling centred.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock first-word-fall-through FIFO; push while full is
//            accepted only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (c_ptr_w + 1)'(DEPTH));
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : 8N1 UART receiver with input synchronizer, framing-error and
//            overflow flags, buffered into a valid/ready byte FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam int c_clks_per_bit = clks_per_bit(CLK_HZ, BAUD);
    localparam int c_half_bit     = c_clks_per_bit / 2;
    localparam int c_cnt_w        = (c_clks_per_bit > 1) ? $clog2(c_clks_per_bit) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_bit_last  = c_cnt_w'(c_clks_per_bit - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_half_last = c_cnt_w'(c_half_bit - 1);

    logic               r_rxd_meta;
    logic               r_rxd_s;
    logic               r_rxd_prev;
    logic [1:0]         r_fill;
    logic               r_armed;
    logic               w_fall;
    logic [c_st_w-1:0]  r_state;
    logic [c_st_w-1:0]  w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               w_cnt_bit_last;
    logic               w_cnt_half_last;
    logic               w_busy;
    logic               w_bit_sample;
    logic               w_stop_ok;
    logic               w_stop_bad;
    logic               r_frame_err;
    logic               r_overflow;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_pop;

    // Starts are ignored until the synchronized line has been seen high after
    // reset, so a line held low through reset cannot fake a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
            r_rxd_prev <= 1'b1;
            r_fill     <= 2'd0;
            r_armed    <= 1'b0;
        end else begin
            r_rxd_meta <= uart_rxd;
            r_rxd_s    <= r_rxd_meta;
            r_rxd_prev <= r_rxd_s;
            if (r_fill != 2'd2) begin
                r_fill <= r_fill + 2'd1;
            end
            if (r_fill == 2'd2 && r_rxd_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_fall          = r_armed & r_rxd_prev & ~r_rxd_s;
    assign w_cnt_bit_last  = (r_cnt == c_cnt_bit_last);
    assign w_cnt_half_last = (r_cnt == c_cnt_half_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_fall) w_state_nxt = c_st_start;
            end
            c_st_start: begin
                if (w_cnt_half_last) w_state_nxt = r_rxd_s ? c_st_idle : c_st_data;
            end
            c_st_data: begin
                if (w_cnt_bit_last && r_bit_idx == 3'd7) w_state_nxt = c_st_stop;
            end
            c_st_stop: begin
                if (w_cnt_bit_last) w_state_nxt = r_rxd_s ? c_st_idle : c_st_break;
            end
            c_st_break: begin
                if (r_rxd_s) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_busy       = (r_state != c_st_idle);
        w_bit_sample = 1'b0;
        w_stop_ok    = 1'b0;
        w_stop_bad   = 1'b0;
        case (r_state)
            c_st_data: w_bit_sample = w_cnt_bit_last;
            c_st_stop: begin
                w_stop_ok  = w_cnt_bit_last & r_rxd_s;
                w_stop_bad = w_cnt_bit_last & ~r_rxd_s;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state || w_bit_sample ||
                     r_state == c_st_idle || r_state == c_st_break) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            if (r_state != c_st_data) begin
                r_bit_idx <= 3'd0;
            end else if (w_bit_sample) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_bit_sample) begin
                r_shift <= {r_rxd_s, r_shift[7:1]};
            end
        end
    end

    assign w_pop = rx_ready & ~w_fifo_empty;

    // A pop in the same cycle frees the slot, so only an unmatched full push drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overflow  <= w_stop_ok & w_fifo_full & ~w_pop;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_stop_ok),
        .din   (r_shift),
        .full  (w_fifo_full),
        .pop   (w_pop),
        .dout  (rx_data),
        .empty (w_fifo_empty)
    );

    assign rx_valid  = ~w_fifo_empty;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;
    assign busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Directed and randomized frames against a queue-based receive model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int CPB   = 10;
    localparam int HALF  = CPB / 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overflow;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int rise_cyc = -1;
    int n_ferr   = 0;
    int n_ovf    = 0;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(
        .CLK_HZ     (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rxd  (uart_rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err === 1'b1) n_ferr <= n_ferr + 1;
        if (overflow === 1'b1)  n_ovf  <= n_ovf + 1;
        if (rx_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc <= cyc;
        prev_valid <= rx_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        uart_rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // stop_low > 0 holds the stop bit low for that many cycles before idling.
    task automatic send_byte(input logic [7:0] b, input int stop_low);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
        if (stop_low > 0) drive_bit(1'b0, stop_low);
        drive_bit(1'b1, CPB);
    endtask

    task automatic drain_expect(input string tag);
        @(negedge clk);
        rx_ready = 1'b1;
        while (exp_q.size() > 0) begin
            check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
            check({tag, "_data"}, {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            @(negedge clk);
        end
        rx_ready = 1'b0;
        check({tag, "_empty"}, {31'd0, rx_valid}, 32'd0);
    endtask

    initial begin
        int ferr0, ovf0, n, exp_ferr, exp_ovf, stop_low;
        logic [7:0] b;

        reset    = 1'b1;
        uart_rxd = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);

        // Single good frame: latency = 3 pin-to-FSM + half bit + 8 data + stop.
        ferr0 = n_ferr; ovf0 = n_ovf;
        send_byte(8'hA5, 0);
        check("a5_latency", rise_cyc - start_cyc, 3 + HALF + 9 * CPB);
        check("a5_flags", (n_ferr - ferr0) + (n_ovf - ovf0), 32'd0);
        exp_q.push_back(8'hA5);
        drain_expect("a5");

        // Three-cycle glitch is rejected at the half-bit start check.
        ferr0 = n_ferr;
        @(posedge clk);
        #1 uart_rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1 uart_rxd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("glitch_busy_hi", {31'd0, busy}, 32'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_lo", {31'd0, busy}, 32'd0);
        repeat (20) @(posedge clk);
        check("glitch_valid", {31'd0, rx_valid}, 32'd0);
        check("glitch_ferr", n_ferr - ferr0, 32'd0);

        // Long low stop bit gives exactly one framing error; next frame still works.
        ferr0 = n_ferr; ovf0 = n_ovf;
        send_byte(8'h3C, 30);
        check("brk_ferr", n_ferr - ferr0, 32'd1);
        check("brk_valid", {31'd0, rx_valid}, 32'd0);
        check("brk_busy", {31'd0, busy}, 32'd0);
        send_byte(8'h55, 0);
        check("brk_ferr_after", n_ferr - ferr0, 32'd1);
        exp_q.push_back(8'h55);
        drain_expect("after_brk");

        // Five bytes into a four-deep FIFO with no consumer.
        ovf0 = n_ovf;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
        check("ovf_count", n_ovf - ovf0, 32'd1);
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        drain_expect("ovf_drain");

        // Full FIFO, pop coincides with the stop-sample push of 0x06.
        ovf0 = n_ovf;
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
        fork
            send_byte(8'h06, 0);
            begin
                @(posedge clk);
                repeat (3 + HALF + 9 * CPB - 1) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        check("simul_ovf", n_ovf - ovf0, 32'd0);
        exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        exp_q.push_back(8'h04); exp_q.push_back(8'h06);
        drain_expect("simul_drain");

        // Reset during the low bit 7 of 0x77, with a byte already buffered.
        ferr0 = n_ferr; ovf0 = n_ovf;
        send_byte(8'h99, 0);
        check("pre_rst_valid", {31'd0, rx_valid}, 32'd1);
        fork
            send_byte(8'h77, 0);
            begin
                @(posedge clk);
                repeat (8 * CPB + HALF - 1) @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
                @(negedge clk);
                check("midrst_valid", {31'd0, rx_valid}, 32'd0);
                check("midrst_data", {24'd0, rx_data}, 32'd0);
                check("midrst_busy", {31'd0, busy}, 32'd0);
            end
        join
        repeat (5) @(posedge clk);
        check("midrst_no_byte", {31'd0, rx_valid}, 32'd0);
        check("midrst_flags", (n_ferr - ferr0) + (n_ovf - ovf0), 32'd0);
        send_byte(8'h88, 0);
        exp_q.push_back(8'h88);
        drain_expect("after_rst");

        // Randomized rounds against a capacity-limited queue model.
        for (int r = 0; r < 4; r++) begin
            ferr0 = n_ferr; ovf0 = n_ovf;
            exp_ferr = 0; exp_ovf = 0;
            n = $urandom_range(1, 7);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                stop_low = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 25) : 0;
                send_byte(b, stop_low);
                if (stop_low > 0) exp_ferr++;
                else if (exp_q.size() < DEPTH) exp_q.push_back(b);
                else exp_ovf++;
                repeat ($urandom_range(0, 15)) @(posedge clk);
            end
            check("rand_ferr", n_ferr - ferr0, exp_ferr);
            check("rand_ovf", n_ovf - ovf0, exp_ovf);
            drain_expect("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
